// File: rtl/stereo_frame_link.sv
// Pairs left/right ADC samples into stereo frames for the reverb core and
// replays processed frames to the DAC sinks. Optional macro: LOOPBACK_EN.
module stereo_frame_link #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic [DATA_W-1:0]             adc_left_data,
    input  logic                          adc_left_valid,
    output logic                          adc_left_ready,
    input  logic [DATA_W-1:0]             adc_right_data,
    input  logic                          adc_right_valid,
    output logic                          adc_right_ready,
    output logic [DATA_W-1:0]             core_in_left,
    output logic [DATA_W-1:0]             core_in_right,
    output logic                          core_in_valid,
    input  logic                          core_in_ready,
    input  logic [DATA_W-1:0]             core_out_left,
    input  logic [DATA_W-1:0]             core_out_right,
    input  logic                          core_out_valid,
    output logic                          core_out_ready,
    output logic [DATA_W-1:0]             dac_left_data,
    output logic                          dac_left_valid,
    input  logic                          dac_left_ready,
    output logic [DATA_W-1:0]             dac_right_data,
    output logic                          dac_right_valid,
    input  logic                          dac_right_ready,
`ifdef LOOPBACK_EN
    input  logic                          loopback_i,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    localparam logic [1:0] WAIT_BOTH = 2'd0;
    localparam logic [1:0] WAIT_L    = 2'd1;
    localparam logic [1:0] WAIT_R    = 2'd2;
    localparam logic [1:0] PRESENT   = 2'd3;

    logic loop;
`ifdef LOOPBACK_EN
    assign loop = loopback_i;
`else
    assign loop = 1'b0;
`endif

    logic              run_q;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              acc_l, acc_r;
    logic              lb_push, frame_out;

    logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]         wr_q, wr_d;
    logic [AW:0]         rd_q, rd_d;
    logic                sent_l_q, sent_l_d;
    logic                sent_r_q, sent_r_d;
    logic [2*DATA_W-1:0] head, push_data;
    logic                full, empty;
    logic                core_push, push, pop;
    logic                xfer_l, xfer_r;

    // Capture side
    assign adc_left_ready  = run_q && (state_q == WAIT_BOTH || state_q == WAIT_L);
    assign adc_right_ready = run_q && (state_q == WAIT_BOTH || state_q == WAIT_R);
    assign acc_l = adc_left_valid && adc_left_ready;
    assign acc_r = adc_right_valid && adc_right_ready;

    assign core_in_valid = (state_q == PRESENT) && !loop;
    assign core_in_left  = left_q;
    assign core_in_right = right_q;

    assign lb_push   = (state_q == PRESENT) && loop && !full;
    assign frame_out = (core_in_valid && core_in_ready) || lb_push;

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_BOTH: begin
                if (acc_l && acc_r) state_d = PRESENT;
                else if (acc_l)     state_d = WAIT_R;
                else if (acc_r)     state_d = WAIT_L;
            end
            WAIT_L:  if (acc_l)     state_d = PRESENT;
            WAIT_R:  if (acc_r)     state_d = PRESENT;
            PRESENT: if (frame_out) state_d = WAIT_BOTH;
            default: state_d = WAIT_BOTH;
        endcase
    end

    assign left_d  = acc_l ? adc_left_data  : left_q;
    assign right_d = acc_r ? adc_right_data : right_q;

    // Return FIFO: extra pointer bit distinguishes full from empty
    assign fifo_level = wr_q - rd_q;
    assign full       = (fifo_level == DEPTH_L);
    assign empty      = (fifo_level == '0);

    assign core_out_ready = run_q && !full && !loop;
    assign core_push      = core_out_valid && core_out_ready;
    assign push           = core_push || lb_push;
    assign push_data      = lb_push ? {left_q, right_q}
                                    : {core_out_left, core_out_right};

    assign head = mem_q[rd_q[AW-1:0]];

    assign dac_left_data   = empty ? '0 : head[2*DATA_W-1:DATA_W];
    assign dac_right_data  = empty ? '0 : head[DATA_W-1:0];
    assign dac_left_valid  = !empty && !sent_l_q;
    assign dac_right_valid = !empty && !sent_r_q;

    assign xfer_l = dac_left_valid && dac_left_ready;
    assign xfer_r = dac_right_valid && dac_right_ready;
    assign pop    = !empty && (sent_l_q || xfer_l) && (sent_r_q || xfer_r);

    assign sent_l_d = pop ? 1'b0 : (sent_l_q || xfer_l);
    assign sent_r_d = pop ? 1'b0 : (sent_r_q || xfer_r);
    assign wr_d     = push ? wr_q + 1'b1 : wr_q;
    assign rd_d     = pop  ? rd_q + 1'b1 : rd_q;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            run_q    <= 1'b0;
            state_q  <= WAIT_BOTH;
            left_q   <= '0;
            right_q  <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            sent_l_q <= 1'b0;
            sent_r_q <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            state_q  <= state_d;
            left_q   <= left_d;
            right_q  <= right_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            sent_l_q <= sent_l_d;
            sent_r_q <= sent_r_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty
    always_ff @(posedge clk_clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: tb/tb_stereo_frame_link.sv
// Bench for stereo_frame_link: queue-based frame model checked every cycle,
// plus directed literal checks. Loopback section built only with LOOPBACK_EN.
module tb_stereo_frame_link;

    localparam int DW = 24;
    localparam int D  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] adc_left_data, adc_right_data;
    logic          adc_left_valid, adc_right_valid;
    logic          adc_left_ready, adc_right_ready;
    logic [DW-1:0] core_in_left, core_in_right;
    logic          core_in_valid, core_in_ready;
    logic [DW-1:0] core_out_left, core_out_right;
    logic          core_out_valid, core_out_ready;
    logic [DW-1:0] dac_left_data, dac_right_data;
    logic          dac_left_valid, dac_right_valid;
    logic          dac_left_ready, dac_right_ready;
    logic [2:0]    fifo_level;
    logic          lb = 1'b0;

    stereo_frame_link #(.DATA_W(DW), .FIFO_DEPTH(D)) dut (
        .clk_clk         (clk),
        .reset_reset_n   (rst_n),
        .adc_left_data   (adc_left_data),
        .adc_left_valid  (adc_left_valid),
        .adc_left_ready  (adc_left_ready),
        .adc_right_data  (adc_right_data),
        .adc_right_valid (adc_right_valid),
        .adc_right_ready (adc_right_ready),
        .core_in_left    (core_in_left),
        .core_in_right   (core_in_right),
        .core_in_valid   (core_in_valid),
        .core_in_ready   (core_in_ready),
        .core_out_left   (core_out_left),
        .core_out_right  (core_out_right),
        .core_out_valid  (core_out_valid),
        .core_out_ready  (core_out_ready),
        .dac_left_data   (dac_left_data),
        .dac_left_valid  (dac_left_valid),
        .dac_left_ready  (dac_left_ready),
        .dac_right_data  (dac_right_data),
        .dac_right_valid (dac_right_valid),
        .dac_right_ready (dac_right_ready),
`ifdef LOOPBACK_EN
        .loopback_i      (lb),
`endif
        .fifo_level      (fifo_level)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: pending-sample flags, a frame queue, sent flags
    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } fr_t;

    bit            m_run = 0, m_hl = 0, m_hr = 0, m_sl = 0, m_sr = 0;
    logic [DW-1:0] m_l = '0, m_r = '0;
    fr_t           m_q[$];

    task automatic model_step();
        bit  al, ar, done, cpush, xl, xr, pop;
        fr_t f;
        if (!rst_n) begin
            m_run = 0; m_hl = 0; m_hr = 0; m_sl = 0; m_sr = 0;
            m_l = '0; m_r = '0;
            m_q.delete();
            return;
        end
        al    = adc_left_valid && m_run && !m_hl;
        ar    = adc_right_valid && m_run && !m_hr;
        done  = m_hl && m_hr && (lb ? (m_q.size() < D) : core_in_ready);
        cpush = core_out_valid && m_run && (m_q.size() < D) && !lb;
        xl    = (m_q.size() > 0) && !m_sl && dac_left_ready;
        xr    = (m_q.size() > 0) && !m_sr && dac_right_ready;
        pop   = (m_q.size() > 0) && (m_sl || xl) && (m_sr || xr);
        if (pop) begin
            void'(m_q.pop_front());
            m_sl = 0; m_sr = 0;
        end else begin
            m_sl = m_sl || xl;
            m_sr = m_sr || xr;
        end
        if (cpush) begin
            f.l = core_out_left; f.r = core_out_right;
            m_q.push_back(f);
        end
        if (done && lb) begin
            f.l = m_l; f.r = m_r;
            m_q.push_back(f);
        end
        if (done) begin m_hl = 0; m_hr = 0; end
        if (al) begin m_hl = 1; m_l = adc_left_data; end
        if (ar) begin m_hr = 1; m_r = adc_right_data; end
        m_run = 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("adc_l_rdy", adc_left_ready,  m_run && !m_hl);
            cmp("adc_r_rdy", adc_right_ready, m_run && !m_hr);
            cmp("cin_valid", core_in_valid,   m_hl && m_hr && !lb);
            if (m_hl && m_hr && !lb) begin
                cmp("cin_l", core_in_left,  m_l);
                cmp("cin_r", core_in_right, m_r);
            end
            cmp("cout_rdy", core_out_ready, m_run && (m_q.size() < D) && !lb);
            cmp("level", fifo_level, m_q.size());
            cmp("dacl_valid", dac_left_valid,  (m_q.size() > 0) && !m_sl);
            cmp("dacr_valid", dac_right_valid, (m_q.size() > 0) && !m_sr);
            if (m_q.size() > 0) begin
                cmp("dacl_data", dac_left_data,  m_q[0].l);
                cmp("dacr_data", dac_right_data, m_q[0].r);
            end
        end
    end

`ifdef LOOPBACK_EN
    bit lb_mon = 1'b0;
    int lb_k = 1;
    always @(negedge clk) begin
        if (lb_mon && dac_left_valid && dac_left_ready) begin
            cmp("lb_l", dac_left_data, lb_k);
            cmp("lb_r", dac_right_data, lb_k);
            cmp("lb_r_valid", dac_right_valid, 1);
            lb_k++;
        end
    end
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0;
        adc_left_data = '0; adc_left_valid = 0;
        adc_right_data = '0; adc_right_valid = 0;
        core_in_ready = 0;
        core_out_left = '0; core_out_right = '0; core_out_valid = 0;
        dac_left_ready = 0; dac_right_ready = 0;

        // Reset and release
        step();
        chk_en = 1;
        step();
        look();
        cmp("rst_adc_l_rdy", adc_left_ready, 0);
        cmp("rst_cout_rdy", core_out_ready, 0);
        cmp("rst_level", fifo_level, 0);
        cmp("rst_dacl_valid", dac_left_valid, 0);
        cmp("rst_cin_l", core_in_left, 0);
        cmp("rst_dacl_data", dac_left_data, 0);
        step(); rst_n = 1;
        look();
        cmp("rel1_adc_l_rdy", adc_left_ready, 0);
        cmp("rel1_adc_r_rdy", adc_right_ready, 0);
        cmp("rel1_cout_rdy", core_out_ready, 0);
        step();
        look();
        cmp("rel2_adc_l_rdy", adc_left_ready, 1);
        cmp("rel2_adc_r_rdy", adc_right_ready, 1);

        // Left in n, right in n+3
        core_in_ready = 1;
        step(); adc_left_valid = 1; adc_left_data = 24'h123456;
        step(); adc_left_valid = 0;
        look();
        cmp("waitr_l_rdy", adc_left_ready, 0);
        cmp("waitr_r_rdy", adc_right_ready, 1);
        step();
        step(); adc_right_valid = 1; adc_right_data = 24'hABCDEF;
        look();
        cmp("n3_cin_valid", core_in_valid, 0);
        step(); adc_right_valid = 0;
        look();
        cmp("n4_cin_valid", core_in_valid, 1);
        cmp("n4_cin_l", core_in_left, 24'h123456);
        cmp("n4_cin_r", core_in_right, 24'hABCDEF);
        step();
        look();
        cmp("n5_cin_valid", core_in_valid, 0);

        // Core stalls; return FIFO fills
        core_in_ready = 0;
        step();
        adc_left_valid = 1; adc_left_data = 24'h111111;
        adc_right_valid = 1; adc_right_data = 24'h222222;
        step(); adc_left_valid = 0; adc_right_valid = 0;
        repeat (10) step();
        look();
        cmp("stall_l_rdy", adc_left_ready, 0);
        cmp("stall_r_rdy", adc_right_ready, 0);
        cmp("stall_cin_l", core_in_left, 24'h111111);
        for (int i = 1; i <= 5; i++) begin
            step();
            core_out_valid = 1;
            core_out_left  = 24'hA00000 + DW'(i);
            core_out_right = 24'hB00000 + DW'(i);
        end
        look();
        cmp("full_level", fifo_level, 4);
        cmp("full_cout_rdy", core_out_ready, 0);
        cmp("full_dacl_data", dac_left_data, 24'hA00001);

        // Left sink ready, right sink stalled
        step(); dac_left_ready = 1; dac_right_ready = 0;
        look();
        cmp("a1_dacl_valid", dac_left_valid, 1);
        step();
        look();
        cmp("a2_dacl_valid", dac_left_valid, 0);
        cmp("a2_dacr_valid", dac_right_valid, 1);
        repeat (3) step();
        step(); dac_right_ready = 1;
        look();
        cmp("a6_level", fifo_level, 4);
        cmp("a6_dacr_data", dac_right_data, 24'hB00001);
        step();
        look();
        cmp("a7_level", fifo_level, 3);
        cmp("a7_dacl_data", dac_left_data, 24'hA00002);
        cmp("a7_cout_rdy", core_out_ready, 1);
        step(); core_out_valid = 0;
        look();
        cmp("a8_level", fifo_level, 3);
        cmp("a8_dacl_data", dac_left_data, 24'hA00003);
        repeat (4) step();
        look();
        cmp("drain_level", fifo_level, 0);
        cmp("drain_dacr_valid", dac_right_valid, 0);

        // Reset with level 3 and a half-captured frame
        step();
        core_in_ready = 1; dac_left_ready = 0; dac_right_ready = 0;
        core_out_valid = 1;
        core_out_left = 24'hC00001; core_out_right = 24'hD00001;
        step(); core_out_left = 24'hC00002; core_out_right = 24'hD00002;
        step(); core_out_left = 24'hC00003; core_out_right = 24'hD00003;
        step(); core_out_valid = 0;
        adc_left_valid = 1; adc_left_data = 24'h555555;
        step(); adc_left_valid = 0;
        look();
        cmp("pre_level", fifo_level, 3);
        cmp("pre_l_rdy", adc_left_ready, 0);
        step(); rst_n = 0;
        step(); rst_n = 1;
        look();
        cmp("post_level", fifo_level, 0);
        cmp("post_dacl_valid", dac_left_valid, 0);
        cmp("post_dacr_valid", dac_right_valid, 0);
        cmp("post_r_rdy", adc_right_ready, 0);
        step();
        look();
        cmp("post2_l_rdy", adc_left_ready, 1);
        cmp("post2_r_rdy", adc_right_ready, 1);
        step(); adc_right_valid = 1; adc_right_data = 24'h777777;
        step(); adc_right_valid = 0;
        look();
        cmp("waitl_l_rdy", adc_left_ready, 1);
        cmp("waitl_r_rdy", adc_right_ready, 0);
        step(); adc_left_valid = 1; adc_left_data = 24'h666666;
        step(); adc_left_valid = 0;
        look();
        cmp("rl_cin_l", core_in_left, 24'h666666);
        cmp("rl_cin_r", core_in_right, 24'h777777);
        step();

`ifdef LOOPBACK_EN
        step();
        lb = 1; lb_mon = 1;
        dac_left_ready = 1; dac_right_ready = 1;
        for (int k = 1; k <= 8; k++) begin
            step();
            adc_left_valid = 1; adc_left_data = DW'(k);
            adc_right_valid = 1; adc_right_data = DW'(k);
            step(); adc_left_valid = 0; adc_right_valid = 0;
        end
        repeat (4) step();
        look();
        cmp("lb_count", lb_k, 9);
        cmp("lb_level", fifo_level, 0);
        step(); lb = 0; lb_mon = 0;
`endif

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stereo_frame_link.md
# stereo_frame_link

Fabric endpoint for the audio controller's Avalon-ST channels. It accepts left and right ADC samples from the controller's source channels and pairs them into one stereo frame for the reverb core. It takes processed frames back from the core, buffers them in a small FIFO, and replays them as separate left and right samples into the controller's DAC sink channels. It sits between the Qsys audio controller conduits and the reverb processing core.

## Interface
- DATA_W, 24, sample width in bits (two's complement).
- FIFO_DEPTH, 4, return-path frame FIFO depth; power of two, ≥2.

Ports:
- clk_clk  in  1  system clock; all logic on the rising edge.
- reset_reset_n  in  1  reset, synchronous, active-low.
- adc_left_data  in  DATA_W  left sample from controller left source.
- adc_left_valid  in  1  left sample valid.
- adc_left_ready  out  1  link accepts left sample.
- adc_right_data / adc_right_valid / adc_right_ready  in/in/out  DATA_W/1/1  same for right.
- core_in_left, core_in_right  out  DATA_W each  paired frame to core.
- core_in_valid  out  1  frame valid.
- core_in_ready  in  1  core accepts frame.
- core_out_left, core_out_right  in  DATA_W each  processed frame from core.
- core_out_valid  in  1  processed frame valid.
- core_out_ready  out  1  FIFO accepts frame.
- dac_left_data / dac_left_valid / dac_left_ready  out/out/in  DATA_W/1/1  to controller left sink.
- dac_right_data / dac_right_valid / dac_right_ready  out/out/in  DATA_W/1/1  to controller right sink.
- fifo_level  out  clog2(FIFO_DEPTH)+1  frames held in return FIFO.
- loopback_i  in  1  only with LOOPBACK_EN (see Configuration).

## Operation
- Transfer on any channel: valid && ready on the same rising edge. Data is held stable while valid && !ready.
- Capture FSM states are WAIT_BOTH, WAIT_L, WAIT_R and PRESENT. Reset state is WAIT_BOTH.
  - WAIT_BOTH: both adc readies high. Left only → WAIT_R. Right only → WAIT_L. Both in the same cycle → PRESENT.
  - WAIT_R: only adc_right_ready high. Right accepted → PRESENT.
  - WAIT_L: only adc_left_ready high. Left accepted → PRESENT.
  - PRESENT: both adc readies low and core_in_valid high. Frame transferred → WAIT_BOTH.
- A second left sample while in WAIT_R is not accepted; ordering is strictly one L and one R per frame.
- Return FIFO: core_out_ready = (fifo_level < FIFO_DEPTH). Push on core_out transfer.
- Playback: the FIFO head drives dac_left_data and dac_right_data. Each channel has a sent flag. dac_x_valid = !empty && !sent_x.
  - The FIFO pops on the edge where the second channel completes, or where both complete together.
  - Both sent flags clear on pop.
- An empty FIFO gives both dac valids low. No zero insertion.
- A push and a pop in the same cycle leave the level unchanged.
- No data bypass: a frame pushed into an empty FIFO is visible on dac outputs the next cycle.

## Timing
- Reset values: all valid and ready outputs 0, all data outputs 0, fifo_level 0, sent flags 0, FSM in WAIT_BOTH.
- Readies are decoded from registered state and a registered run bit (reset 0, set on the first edge with reset_reset_n high). adc readies therefore rise one cycle after reset release.
- Capture latency: core_in_valid is high the cycle after the second sample of a frame is accepted.
- Return latency: dac valids are high the cycle after a core_out push into an empty FIFO.
- Throughput: one frame per 2 cycles on the capture path. On playback, one frame per cycle when both dac readies are held high.
- Reset asserted mid-operation: on the next edge, partially captured samples and FIFO contents are discarded and all reset values apply.

## Configuration
- Macro LOOPBACK_EN.
- Defined: port loopback_i exists. While loopback_i=1:
  - core_in_valid is forced 0 and core_out_ready is forced 0.
  - The PRESENT frame pushes into the return FIFO when it is not full, then moves to WAIT_BOTH.
  - loopback_i is evaluated every cycle. A frame takes exactly one path and is never duplicated or dropped.
- Undefined: no port; behaviour identical to loopback_i=0.

## Test plan
- Reset release: adc readies 0 in the first cycle after release and 1 in the second; all other outputs 0.
- Left 0x123456 in cycle n, right 0xABCDEF in n+3, core_in_ready=1 → core_in_left/right = 0x123456/0xABCDEF with valid in n+4 only.
- Core holds ready low for 10 cycles with FIFO_DEPTH=4 → adc readies stay 0, frame stable. Then push 5 core frames → core_out_ready drops after 4, fifo_level=4.
- dac_left_ready=1, dac_right_ready=0 for 5 cycles, then 1 → left transferred once, FIFO pops in the right's cycle, next frame follows in order.
- Reset asserted while fifo_level=3 and FSM in WAIT_R → next cycle fifo_level=0, dac valids 0, FSM in WAIT_BOTH.
- LOOPBACK_EN, loopback_i=1: 8 frames 0x000001..0x000008 on both channels with dac readies high → identical samples on dac outputs in order, core_in_valid never 1.
